// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Holds the rotating priority search and the 2-to-4 decode slice.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scan from the highest offset down so the lowest offset from ptr is written last and wins.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] vec, input logic [IDX_W-1:0] ptr);
        pick_t            r;
        logic [IDX_W-1:0] j;
        r = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = ptr + IDX_W'(k);
            if (vec[j]) begin
                r.found = 1'b1;
                r.idx   = j;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] dec2to4(input logic [1:0] sel, input logic en);
        logic [3:0] r;
        r      = '0;
        r[sel] = en;
        return r;
    endfunction

endpackage

// File: rtl/dec3to8.sv
// Index-to-one-hot decoder built from two enabled 2-to-4 slices.
module dec3to8
    import rr_arb_pkg::*;
(
    input  logic [2:0] i,
    output logic [7:0] o
);

    // i[2] steers the shared low bits into the upper or lower half.
    assign o = {dec2to4(i[1:0], i[2]), dec2to4(i[1:0], ~i[2])};

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with grant locking and optional
// forced rotation after MAX_HOLD consecutive cycles when others are waiting.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    output logic [N_REQ-1:0]     gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_valid,
    output logic                 preempt
);

    localparam bit               PREEMPT_EN = (MAX_HOLD > 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(PREEMPT_EN ? MAX_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_SAT   = '1;

    arb_state_t       state, state_nx;
    logic [CNT_W-1:0] hold_cnt, hold_nx;
    logic [IDX_W-1:0] ptr, ptr_nx, idx_nx;
    logic             valid_nx, preempt_nx, new_grant;
    logic [N_REQ-1:0] cand, dec_nx, gnt_nx;
    pick_t            pick;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        cand       = (state == GRANT) ? (req & ~gnt) : req;
        pick       = rr_pick(cand, ptr);
        state_nx   = state;
        hold_nx    = hold_cnt;
        ptr_nx     = ptr;
        idx_nx     = gnt_idx;
        valid_nx   = gnt_valid;
        preempt_nx = 1'b0;
        new_grant  = 1'b0;

        case (state)
            IDLE: begin
                if (pick.found) new_grant = 1'b1;
            end
            GRANT: begin
                // Release is tested first so it overrides a coincident hold expiry.
                if (!req[gnt_idx]) begin
                    if (pick.found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        valid_nx = 1'b0;
                        hold_nx  = '0;
                    end
                end else if (PREEMPT_EN && hold_cnt == HOLD_LAST && pick.found) begin
                    new_grant  = 1'b1;
                    preempt_nx = 1'b1;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (new_grant) begin
            state_nx = GRANT;
            idx_nx   = pick.idx;
            valid_nx = 1'b1;
            ptr_nx   = pick.idx + 1'b1;
            hold_nx  = '0;
        end
    end

    dec3to8 u_dec (
        .i (idx_nx),
        .o (dec_nx)
    );

    assign gnt_nx = valid_nx ? dec_nx : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            ptr       <= ptr_nx;
            gnt       <= gnt_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
            preempt   <= preempt_nx;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench: three arbiters (MAX_HOLD 4, 0, 2) share one stimulus stream
// and are compared each cycle against a request-level round-robin model.
module tb_rr_arbiter8;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;

    logic [7:0] gnt_o   [NI];
    logic [2:0] idx_o   [NI];
    logic       valid_o [NI];
    logic       pre_o   [NI];

    rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[0]), .gnt_idx(idx_o[0]),
        .gnt_valid(valid_o[0]), .preempt(pre_o[0]));
    rr_arbiter8 #(.MAX_HOLD(0), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[1]), .gnt_idx(idx_o[1]),
        .gnt_valid(valid_o[1]), .preempt(pre_o[1]));
    rr_arbiter8 #(.MAX_HOLD(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[2]), .gnt_idx(idx_o[2]),
        .gnt_valid(valid_o[2]), .preempt(pre_o[2]));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NI-1:0][7:0] gnt;
        logic [NI-1:0][2:0] idx;
        logic [NI-1:0]      valid;
        logic [NI-1:0]      pre;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Model: owner (-1 when idle), how many cycles it has held so far, rotating priority start.
    int owner  [NI];
    int cycles [NI];
    int prio   [NI];

    function automatic int max_hold_of(input int inst);
        case (inst)
            0:       return 4;
            1:       return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int first_from(input logic [7:0] v, input int start);
        for (int k = 0; k < 8; k++) begin
            if (v[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic check(input string nm, input int inst, input int c,
                         input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d got %h expected %h", nm, inst, c, got, want);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge.
    task automatic drive(input logic r, input logic [7:0] rq);
        exp_t e;
        int   w;
        logic [7:0] others;
        @(negedge clk);
        rst = r;
        req = rq;
        cyc++;
        e     = '0;
        e.cyc = cyc;
        for (int i = 0; i < NI; i++) begin
            if (r) begin
                owner[i]  = -1;
                cycles[i] = 0;
                prio[i]   = 0;
            end else if (owner[i] < 0) begin
                w = first_from(rq, prio[i]);
                if (w >= 0) begin
                    owner[i] = w; cycles[i] = 1; prio[i] = (w + 1) % 8;
                end
            end else begin
                others            = rq;
                others[owner[i]]  = 1'b0;
                w                 = first_from(others, prio[i]);
                if (!rq[owner[i]]) begin
                    if (w >= 0) begin
                        owner[i] = w; cycles[i] = 1; prio[i] = (w + 1) % 8;
                    end else begin
                        owner[i] = -1; cycles[i] = 0;
                    end
                end else if (max_hold_of(i) > 0 && cycles[i] == max_hold_of(i) && w >= 0) begin
                    owner[i] = w; cycles[i] = 1; prio[i] = (w + 1) % 8;
                    e.pre[i] = 1'b1;
                end else begin
                    cycles[i]++;
                end
            end
            if (owner[i] >= 0) begin
                e.gnt[i]   = 8'(1 << owner[i]);
                e.idx[i]   = 3'(owner[i]);
                e.valid[i] = 1'b1;
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < NI; i++) begin
                    check("gnt",       i, e.cyc, gnt_o[i],                 e.gnt[i]);
                    check("gnt_idx",   i, e.cyc, {5'b0, idx_o[i]},         {5'b0, e.idx[i]});
                    check("gnt_valid", i, e.cyc, {7'b0, valid_o[i]},       {7'b0, e.valid[i]});
                    check("preempt",   i, e.cyc, {7'b0, pre_o[i]},         {7'b0, e.pre[i]});
                end
            end
        end
    end

    initial begin
        logic [7:0] m;
        logic [7:0] rq;
        logic       r;
        for (int i = 0; i < NI; i++) begin
            owner[i] = -1; cycles[i] = 0; prio[i] = 0;
        end

        // Reset then a single request, then release.
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h04);
        drive(1'b0, 8'h04);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);

        // Rotation: every requester asks, the current owner drops after one granted cycle.
        drive(1'b1, 8'h00);
        repeat (10) begin
            m = 8'hFF;
            if (owner[1] >= 0) m[owner[1]] = 1'b0;
            drive(1'b0, m);
        end
        drive(1'b0, 8'h00);

        // Preemption: 3 holds, 5 arrives two cycles after the grant.
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h08);
        drive(1'b0, 8'h08);
        drive(1'b0, 8'h08);
        repeat (8) drive(1'b0, 8'h28);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);

        // Back-to-back handoff 6 -> 7 -> 0 with wrap of the priority pointer.
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h40);
        drive(1'b0, 8'hC3);
        drive(1'b0, 8'h83);
        drive(1'b0, 8'h03);
        drive(1'b0, 8'h00);

        // Reset in the middle of a grant with every request high.
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h10);
        drive(1'b0, 8'h10);
        drive(1'b1, 8'hFF);
        drive(1'b0, 8'hFF);
        drive(1'b0, 8'hFF);
        drive(1'b0, 8'h00);

        // Release coinciding with hold expiry on the MAX_HOLD=2 instance.
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h02);
        drive(1'b0, 8'h06);
        drive(1'b0, 8'h04);
        drive(1'b0, 8'h04);
        drive(1'b0, 8'h00);

        // Random: requests toggle sparsely so grants last several cycles; occasional reset.
        rq = 8'h00;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            rq = rq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            drive(r, rq);
        end
        drive(1'b0, 8'h00);

        @(posedge clk);
        #2;
        check("sb_drain", 0, cyc, 8'(sb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource between 8 requesters.
- Produces a registered one-hot grant vector and a 3-bit grant index.
- The one-hot vector comes from the index through a 3-to-8 decoder.
- Sits in front of any shared datapath (bus, memory port, display segment) selected by a one-hot enable.
- Supports grant locking while the request stays high, plus optional forced rotation after a maximum hold time.

Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles before preemption when another requester waits; 0 disables preemption.
- CNT_W, 4: hold counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  8  request per requester; requester holds high until done.
- gnt  out  8  one-hot grant; all zero when idle.
- gnt_idx  out  3  index of the granted requester; 0 when idle.
- gnt_valid  out  1  high when gnt is non-zero.
- preempt  out  1  one-cycle pulse in the cycle a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, hold_cnt=0.
  - Priority pointer ptr=0, i.e. requester 0 has highest priority.
  - rst has priority over all other events, including mid-grant; the grant drops on the next edge.
- Priority search: the first set bit of the candidate vector scanning ptr, ptr+1, ..., ptr+7, wrapping modulo 8.
- IDLE:
  - If req!=0, the winner is taken from req and the next state is GRANT.
  - gnt/gnt_idx/gnt_valid are registered, so latency is 1 cycle from req to gnt.
  - If req==0, stay in IDLE.
- GRANT, current index c:
  - Release: req[c]=0.
    - Candidate vector = req with bit c cleared.
    - If non-zero, grant the winner next cycle (back-to-back, no idle gap).
    - Otherwise go to IDLE and clear gnt.
  - Preempt: MAX_HOLD>0, hold_cnt==MAX_HOLD-1, req[c]=1, and another bit of req is set.
    - Grant the winner among the others next cycle.
    - preempt=1 for exactly that one cycle, coincident with the new grant.
    - Requester c keeps its request and re-competes normally.
  - Otherwise: keep the grant and increment hold_cnt, saturating at 2**CNT_W-1.
  - If there is no other requester, the grant persists indefinitely regardless of MAX_HOLD.
- Pointer update:
  - On every new grant to index w, ptr := (w+1) mod 8 (3-bit wrap, 7→0).
  - hold_cnt := 0 on every new grant.
- Simultaneous release and preempt condition: release wins; preempt stays 0.
- gnt is always the decode of gnt_idx when gnt_valid=1, and exactly one bit is set.
- Undefined (X) req bits are not expected; no X-masking is required.

Decomposition:
- Package rr_arb_pkg:
  - localparam N_REQ=8, IDX_W=3.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - function rr_pick(vec[7:0], ptr[2:0]) returning found flag and index.
- Sub-module dec3to8: combinational index-to-one-hot decoder.
  - Input [2:0] i, output [7:0] o.
  - Built hierarchically from two 2-to-4 decoders as the team's existing decoders are.
  - Instantiated on the next-index path; its output is registered into gnt.

Test Plan:
- Reset then single request: rst 1 cycle, req=8'b0000_0100 → next cycle gnt=8'h04, gnt_idx=2, gnt_valid=1.
  - Drop req → following cycle gnt=0, gnt_valid=0.
- Rotation:
  - After reset, req=8'hFF held with MAX_HOLD=0, each grantee dropping its req for one cycle after being granted 1 cycle.
  - Required grant order: 0,1,2,...,7, then 0 (wrap of ptr from 7 to 0).
  - No idle gaps.
- Preemption:
  - MAX_HOLD=4; req[3]=1 held, req[5] raised 2 cycles after gnt[3].
  - gnt[3] lasts exactly 4 cycles.
  - Then gnt=8'h20, gnt_idx=5, with preempt=1 in that single cycle.
- Back-to-back handoff: gnt_idx=6 active, req=8'b1000_0011, req[6] drops → next cycle gnt_idx=7; after req[7] drops → gnt_idx=0.
- Reset mid-grant: gnt_idx=4 active, assert rst for 1 cycle with req=8'hFF → outputs zero after that edge; next grant goes to index 0.
- Simultaneous release and expiry: MAX_HOLD=2; req[1] drops in the same cycle hold_cnt reaches 1, with req[2] pending → gnt_idx=2, preempt=0.
